// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: once per eligible frame, grants one requesting enemy
// (round-robin) a free bullet slot, then waits COOLDOWN_FRAMES frames.
module enemy_fire_scheduler #(
   parameter int AMOUNT_OF_ENEMIES = 2,
   parameter int BULLET_SLOTS      = 4,
   parameter int COOLDOWN_FRAMES   = 30
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic                         startOfFrame,
   input  logic                         pause,
   input  logic [AMOUNT_OF_ENEMIES-1:0] fireReq,
   input  logic [BULLET_SLOTS-1:0]      bulletDone,
   output logic                         grantValid,
   output logic [3:0]                   grantId,
   output logic [2:0]                   grantSlot,
   output logic [BULLET_SLOTS-1:0]      slotBusy,
   output logic [3:0]                   activeBullets
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARBITRATE = 2'd1,
      GRANT     = 2'd2,
      COOLDOWN  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              rr_ptr_q, rr_ptr_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [BULLET_SLOTS-1:0] busy_q, busy_d;
   logic                    gv_q, gv_d;
   logic [3:0]              gid_q, gid_d;
   logic [2:0]              gslot_q, gslot_d;

   logic                    sof_run_s;
   logic                    win_found_s;
   logic [3:0]              win_id_s;
   logic                    slot_found_s;
   logic [2:0]              slot_id_s;

   function automatic logic [3:0] popcount(input logic [BULLET_SLOTS-1:0] v);
      logic [3:0] c;
      c = 4'd0;
      for (int k = 0; k < BULLET_SLOTS; k++) begin
         c = c + 4'(v[k]);
      end
      return c;
   endfunction

   assign sof_run_s = startOfFrame & ~pause;

   // Round-robin winner: first set request at or above rr_ptr_q, wrapping.
   always_comb begin
      logic [4:0]                   idx;
      logic [AMOUNT_OF_ENEMIES-1:0] req_sh;
      idx         = 5'd0;
      req_sh      = '0;
      win_found_s = 1'b0;
      win_id_s    = 4'd0;
      for (int i = 0; i < AMOUNT_OF_ENEMIES; i++) begin
         idx = {1'b0, rr_ptr_q} + 5'(i);
         if (idx >= 5'(AMOUNT_OF_ENEMIES)) begin
            idx = idx - 5'(AMOUNT_OF_ENEMIES);
         end else begin
            idx = idx;
         end
         req_sh = fireReq >> idx;
         if (!win_found_s && req_sh[0]) begin
            win_found_s = 1'b1;
            win_id_s    = idx[3:0];
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Lowest-index free slot; scanning downward leaves the lowest one last.
   always_comb begin
      slot_found_s = 1'b0;
      slot_id_s    = 3'd0;
      for (int k = BULLET_SLOTS - 1; k >= 0; k--) begin
         if (!busy_q[k]) begin
            slot_found_s = 1'b1;
            slot_id_s    = 3'(k);
         end else begin
            slot_id_s = slot_id_s;
         end
      end
   end

   // Next-state, slot bookkeeping and grant outputs.
   always_comb begin
      logic [3:0] nxt_ptr;
      nxt_ptr  = 4'd0;
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      cnt_d    = cnt_q;
      gv_d     = 1'b0;
      gid_d    = 4'd0;
      gslot_d  = 3'd0;
      busy_d   = busy_q & ~bulletDone;
      case (state_q)
         IDLE: begin
            if (sof_run_s) begin
               state_d = ARBITRATE;
            end else begin
               state_d = IDLE;
            end
         end
         ARBITRATE: begin
            if (win_found_s && slot_found_s) begin
               state_d = GRANT;
               gv_d    = 1'b1;
               gid_d   = win_id_s;
               gslot_d = slot_id_s;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            busy_d  = busy_d | (BULLET_SLOTS'(1'b1) << gslot_q);
            nxt_ptr = gid_q + 4'd1;
            if (nxt_ptr == 4'(AMOUNT_OF_ENEMIES)) begin
               rr_ptr_d = 4'd0;
            end else begin
               rr_ptr_d = nxt_ptr;
            end
            cnt_d = 8'(COOLDOWN_FRAMES);
            if (COOLDOWN_FRAMES > 0) begin
               state_d = COOLDOWN;
            end else begin
               state_d = IDLE;
            end
         end
         COOLDOWN: begin
            if (sof_run_s) begin
               cnt_d = cnt_q - 8'd1;
               if (cnt_q == 8'd1) begin
                  state_d = IDLE;
               end else begin
                  state_d = COOLDOWN;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= IDLE;
         rr_ptr_q <= 4'd0;
         cnt_q    <= 8'd0;
         busy_q   <= '0;
         gv_q     <= 1'b0;
         gid_q    <= 4'd0;
         gslot_q  <= 3'd0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         gv_q     <= gv_d;
         gid_q    <= gid_d;
         gslot_q  <= gslot_d;
      end
   end

   assign grantValid    = gv_q;
   assign grantId       = gid_q;
   assign grantSlot     = gslot_q;
   assign slotBusy      = busy_q;
   assign activeBullets = popcount(busy_q);

endmodule
